// File: rtl/cam_pixel_capture_pkg.sv
// Shared types and constants for the OV7670 DVP capture front end.
package CamCaptureTypes;

  localparam int unsigned CAM_WORD_W = 17;
  localparam logic [CAM_WORD_W-1:0] FRAME_START_MARKER = 17'h10000;

  typedef enum logic [2:0] {StSync, StBlank, StMarker, StActive, StDrop} cam_state_e;

  function automatic logic [CAM_WORD_W-1:0] pixel_word(input logic [15:0] pix);
    return {1'b0, pix};
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera input bus plus camera-FIFO write side and status flags of the capture block.
interface cam_pixel_capture_if;
  import CamCaptureTypes::*;

  logic                  capture_en;
  logic                  cam_vsync;
  logic                  cam_href;
  logic [7:0]            cam_data;
  logic                  fifo_full;
  logic [CAM_WORD_W-1:0] fifo_data;
  logic                  fifo_wr_en;
  logic                  frame_done;
  logic                  overflow;
  logic                  size_error;

  modport master (
    input  capture_en, cam_vsync, cam_href, cam_data, fifo_full,
    output fifo_data, fifo_wr_en, frame_done, overflow, size_error
  );

  modport slave (
    output capture_en, cam_vsync, cam_href, cam_data, fifo_full,
    input  fifo_data, fifo_wr_en, frame_done, overflow, size_error
  );
endinterface

// File: rtl/cam_pixel_capture_sync_edge.sv
// Registers one sync input and derives rise/fall pulses from the registered copies.
module cam_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  assign level = s1_q;
  assign rise  = s1_q & ~s2_q;
  assign fall  = ~s1_q & s2_q;

endmodule

// File: rtl/cam_pixel_capture.sv
// OV7670 RGB565 pixel assembler feeding the camera FIFO with a per-frame start marker.
// Define CAM_TEST_PATTERN_EN to replace pixel data with a {line, pixel} index pattern.
module cam_pixel_capture
  import CamCaptureTypes::*;
#(
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic                clk,
  input  logic                reset_n,
  cam_pixel_capture_if.master bus
);

  localparam int unsigned PixW  = $clog2(FRAME_WIDTH + 1);
  localparam int unsigned LineW = $clog2(FRAME_HEIGHT + 1);
  localparam logic [PixW-1:0]  PixMax  = PixW'(FRAME_WIDTH);
  localparam logic [LineW-1:0] LineMax = LineW'(FRAME_HEIGHT);

  logic vs, vs_rise, vs_fall;
  logic hr, hr_rise, hr_fall;

  cam_sync_edge u_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.cam_vsync),
    .level   (vs),
    .rise    (vs_rise),
    .fall    (vs_fall)
  );

  cam_sync_edge u_href (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (bus.cam_href),
    .level   (hr),
    .rise    (hr_rise),
    .fall    (hr_fall)
  );

  cam_state_e            state_q;
  logic [7:0]            data_q, hi_q;
  logic                  en_q, phase_q, wr_q, done_q, ovf_q, size_q;
  logic [CAM_WORD_W-1:0] word_q;
  logic [PixW-1:0]       pix_q;
  logic [LineW-1:0]      line_q;

  logic             wr_blocked, line_close;
  logic [LineW-1:0] line_next;
  logic [15:0]      pix_val;

  assign wr_blocked = wr_q & bus.fifo_full;
  // A vsync rise with href still high closes the open line in the same cycle.
  assign line_close = hr_fall | (vs_rise & hr);
  assign line_next  = (line_q == LineMax) ? line_q : line_q + 1'b1;

`ifdef CAM_TEST_PATTERN_EN
  assign pix_val = {8'(line_q), 8'(pix_q)};
`else
  assign pix_val = {hi_q, data_q};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StSync;
      data_q  <= '0;
      hi_q    <= '0;
      en_q    <= 1'b0;
      phase_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      size_q  <= 1'b0;
      word_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      en_q   <= bus.capture_en;
      data_q <= bus.cam_data;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (wr_blocked) ovf_q <= 1'b1;
      unique case (state_q)
        StSync: if (vs) state_q <= StBlank;
        StBlank: begin
          if (vs_fall && en_q) begin
            ovf_q   <= 1'b0;
            size_q  <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            phase_q <= 1'b0;
            wr_q    <= 1'b1;
            word_q  <= FRAME_START_MARKER;
            state_q <= StMarker;
          end
        end
        StMarker: state_q <= wr_blocked ? StDrop : StActive;
        StActive: begin
          if (vs_rise) begin
            phase_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StBlank;
            if (line_close) begin
              line_q <= line_next;
              if (phase_q || pix_q != PixMax || line_next != LineMax) size_q <= 1'b1;
            end else if (line_q != LineMax) begin
              size_q <= 1'b1;
            end
          end else if (wr_blocked) begin
            state_q <= StDrop;
          end else if (line_close) begin
            line_q  <= line_next;
            phase_q <= 1'b0;
            if (phase_q || pix_q != PixMax) size_q <= 1'b1;
          end else if (hr) begin
            if (hr_rise) pix_q <= '0;
            if (!phase_q) begin
              hi_q    <= data_q;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (pix_q == PixMax || line_q == LineMax) begin
                size_q <= 1'b1;
              end else begin
                pix_q  <= pix_q + 1'b1;
                wr_q   <= 1'b1;
                word_q <= pixel_word(pix_val);
              end
            end
          end else begin
            phase_q <= 1'b0;
          end
        end
        StDrop: begin
          if (vs_rise) begin
            done_q  <= 1'b1;
            state_q <= StBlank;
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  // Gate on the live full flag so a write is never issued into a full FIFO.
  assign bus.fifo_wr_en = wr_q & ~bus.fifo_full;
  assign bus.fifo_data  = word_q;
  assign bus.frame_done = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.size_error = size_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture on a 23x17 frame with a FIFO write scoreboard.
module tb_cam_pixel_capture;
  import CamCaptureTypes::*;

  localparam int W = 23;
  localparam int H = 17;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cam_pixel_capture_if bus ();

  cam_pixel_capture #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks, n_errors;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int done_cnt, pix_seen, full_at, exp_limit, exp_pix;
  bit full_arm;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fifo_wr_en === 1'b1) begin
      got_q.push_back(bus.fifo_data);
      if (bus.fifo_data[16] == 1'b0) pix_seen++;
      if (full_at != 0 && pix_seen == full_at) full_arm = 1'b1;
    end
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (full_arm) bus.fifo_full = 1'b1;
  endtask

  function automatic logic [16:0] exp_word(input int l, input int p, input logic [15:0] px);
`ifdef CAM_TEST_PATTERN_EN
    return {1'b0, 8'(l), 8'(p)};
`else
    return {1'b0, px};
`endif
  endfunction

  task automatic send_frame(input bit en, input int n_lines, input int long_line,
                            input int rst_line);
    bit live;
    live = en;
    bus.capture_en = en;
    bus.cam_vsync  = 1'b1;
    repeat (4) tick();
    bus.cam_vsync = 1'b0;
    if (live) exp_q.push_back(17'h10000);
    repeat (4) tick();
    for (int l = 0; l < n_lines; l++) begin
      int np;
      np = (l == long_line) ? W + 2 : W;
      for (int p = 0; p < np; p++) begin
        logic [15:0] px;
        if (l == rst_line && p == 10) begin
          reset_n = 1'b0;
          #1;
          check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
          check_eq("rst_data", 32'(bus.fifo_data), 32'd0);
          check_eq("rst_done", 32'(bus.frame_done), 32'd0);
          check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
          check_eq("rst_size_error", 32'(bus.size_error), 32'd0);
          repeat (2) tick();
          reset_n = 1'b1;
          got_q.delete();
          exp_q.delete();
          done_cnt = 0;
          pix_seen = 0;
          live     = 1'b0;
        end
        px = 16'($urandom);
        bus.cam_href = 1'b1;
        bus.cam_data = px[15:8];
        tick();
        bus.cam_data = px[7:0];
        tick();
        if (live && p < W && l < H && exp_pix < exp_limit) begin
          exp_q.push_back(exp_word(l, p, px));
          exp_pix++;
        end
      end
      bus.cam_href = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic end_frame();
    bus.cam_vsync = 1'b1;
    repeat (6) tick();
  endtask

  task automatic frame_check(input string tag, input int exp_n, input int exp_done,
                             input bit exp_ovf, input bit exp_size);
    check_eq({tag, "_count"}, got_q.size(), exp_n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq({tag, "_done"}, done_cnt, exp_done);
    check_eq({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    check_eq({tag, "_size_error"}, 32'(bus.size_error), 32'(exp_size));
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    pix_seen = 0;
    exp_pix  = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    pix_seen  = 0;
    full_at   = 0;
    full_arm  = 1'b0;
    exp_limit = 1000;
    exp_pix   = 0;
    reset_n        = 1'b0;
    bus.capture_en = 1'b0;
    bus.cam_vsync  = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_data   = 8'h00;
    bus.fifo_full  = 1'b0;
    repeat (3) tick();
    check_eq("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check_eq("reset_data", 32'(bus.fifo_data), 32'd0);
    check_eq("reset_done", 32'(bus.frame_done), 32'd0);
    check_eq("reset_overflow", 32'(bus.overflow), 32'd0);
    check_eq("reset_size_error", 32'(bus.size_error), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full frame: marker plus 391 pixels.
    send_frame(1'b1, H, -1, -1);
    end_frame();
`ifdef CAM_TEST_PATTERN_EN
    if (got_q.size() > 74) check_eq("pattern_l3p4", 32'(got_q[74]), 32'h00304);
    else check_eq("pattern_l3p4_present", got_q.size(), 75);
`endif
    frame_check("normal", 392, 1, 1'b0, 1'b0);

    // Capture disabled at frame start, then a normal frame.
    send_frame(1'b0, H, -1, -1);
    end_frame();
    frame_check("skipped", 0, 0, 1'b0, 1'b0);
    send_frame(1'b1, H, -1, -1);
    end_frame();
    frame_check("after_skip", 392, 1, 1'b0, 1'b0);

    // FIFO goes full after the 99th pixel.
    full_at   = 99;
    exp_limit = 99;
    send_frame(1'b1, H, -1, -1);
    end_frame();
    frame_check("overflow", 100, 1, 1'b1, 1'b0);
    full_at       = 0;
    full_arm      = 1'b0;
    exp_limit     = 1000;
    bus.fifo_full = 1'b0;
    send_frame(1'b1, H, -1, -1);
    end_frame();
    frame_check("after_ovf", 392, 1, 1'b0, 1'b0);

    // Geometry errors: over-long line 5, then a 16-line frame.
    send_frame(1'b1, H, 5, -1);
    end_frame();
    frame_check("long_line", 392, 1, 1'b0, 1'b1);
    send_frame(1'b1, H - 1, -1, -1);
    check_eq("short_pre_vsync", 32'(bus.size_error), 32'd0);
    end_frame();
    frame_check("short_frame", 369, 1, 1'b0, 1'b1);

    // Reset mid-line 8, then capture resumes on the next frame.
    send_frame(1'b1, H, -1, 8);
    end_frame();
    frame_check("after_reset", 0, 0, 1'b0, 1'b0);
    send_frame(1'b1, H, -1, -1);
    end_frame();
    frame_check("resumed", 392, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
